// File: rtl/ysyx_24100005_lsu_pkg.sv
// Shared definitions for the LSU: RV32 load/store funct3 codes, FSM states, legality check.
package ysyx_24100005_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // A memory op is legal when exactly one of ren/wen is set, funct3 is known and the address is aligned.
  function automatic logic op_legal(input logic ren, input logic wen,
                                    input logic [2:0] funct3, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (ren && !wen) begin
      case (funct3)
        F3_LB, F3_LBU: ok = 1'b1;
        F3_LH, F3_LHU: ok = ~off[0];
        F3_LW:         ok = (off == 2'b00);
        default:       ok = 1'b0;
      endcase
    end else if (wen && !ren) begin
      case (funct3)
        F3_SB:   ok = 1'b1;
        F3_SH:   ok = ~off[0];
        F3_SW:   ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_align.sv
// Byte-lane alignment: store mask/shift and load extract with sign/zero extension (combinational).
module ysyx_24100005_lsu_align
  import ysyx_24100005_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] st_data,
  output logic [3:0]        st_wmask,
  output logic [DATA_W-1:0] st_wdata,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] ld_word,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] ld_shift;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  // Store byte-lane strobe from access size and offset
  always_comb begin
    st_wmask = 4'b0000;
    case (st_funct3)
      F3_SB:   st_wmask = 4'b0001 << st_off;
      F3_SH:   st_wmask = 4'b0011 << st_off;
      F3_SW:   st_wmask = 4'b1111;
      default: st_wmask = 4'b0000;
    endcase
  end

  assign st_wdata = st_data << {st_off, 3'b000};

  assign ld_shift = ld_word >> {ld_off, 3'b000};
  assign ld_byte  = ld_shift[7:0];
  assign ld_half  = ld_shift[15:0];

  // Load extraction and extension
  always_comb begin
    ld_data = '0;
    case (ld_funct3)
      F3_LB:   ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      F3_LW:   ld_data = ld_shift;
      F3_LBU:  ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      F3_LHU:  ld_data = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Load/store unit: single-outstanding memory port with request/ack, results via valid/ready.
// Optional ack timeout enabled by defining YSYX_LSU_TIMEOUT_EN.
module ysyx_24100005_lsu
  import ysyx_24100005_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_ren,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [2:0]        in_funct3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state, state_n;
  logic              op_ren, op_ren_n;
  logic [2:0]        op_funct3, op_funct3_n;
  logic [1:0]        op_off, op_off_n;
  logic              out_valid_n, out_err_n;
  logic [DATA_W-1:0] out_rdata_n;
  logic              mem_req_n, mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic [3:0]        mem_wmask_n;

  logic              legal;
  logic [3:0]        st_wmask;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] ld_data;

`ifdef YSYX_LSU_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              timeout_hit;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic              unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  assign in_ready = (state == ST_IDLE) & ~rst;
  assign legal    = op_legal(in_ren, in_wen, in_funct3, in_addr[1:0]);

  ysyx_24100005_lsu_align #(.DATA_W(DATA_W)) u_align (
    .st_funct3 (in_funct3),
    .st_off    (in_addr[1:0]),
    .st_data   (in_wdata),
    .st_wmask  (st_wmask),
    .st_wdata  (st_wdata),
    .ld_funct3 (op_funct3),
    .ld_off    (op_off),
    .ld_word   (mem_rdata),
    .ld_data   (ld_data)
  );

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    op_ren_n    = op_ren;
    op_funct3_n = op_funct3;
    op_off_n    = op_off;
    out_valid_n = out_valid;
    out_err_n   = out_err;
    out_rdata_n = out_rdata;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_wmask_n = mem_wmask;
`ifdef YSYX_LSU_TIMEOUT_EN
    cnt_n       = cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op_ren_n    = in_ren;
          op_funct3_n = in_funct3;
          op_off_n    = in_addr[1:0];
          if (legal) begin
            state_n     = ST_REQ;
            mem_req_n   = 1'b1;
            mem_we_n    = in_wen;
            mem_addr_n  = {in_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_n = st_wdata;
            mem_wmask_n = in_wen ? st_wmask : 4'b0000;
`ifdef YSYX_LSU_TIMEOUT_EN
            cnt_n       = '0;
`endif
          end else begin
            // No-op (neither strobe) completes cleanly; anything else here is an error
            state_n     = ST_RESP;
            out_err_n   = in_ren | in_wen;
            out_rdata_n = '0;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_n     = ST_RESP;
          mem_req_n   = 1'b0;
          out_err_n   = 1'b0;
          out_rdata_n = op_ren ? ld_data : '0;
        end
`ifdef YSYX_LSU_TIMEOUT_EN
        else if (timeout_hit) begin
          state_n     = ST_RESP;
          mem_req_n   = 1'b0;
          out_err_n   = 1'b1;
          out_rdata_n = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
`endif
      end
      ST_RESP: begin
        if (!out_valid) begin
          out_valid_n = 1'b1;
        end else if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_ren    <= 1'b0;
      op_funct3 <= 3'b000;
      op_off    <= 2'b00;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= 4'b0000;
`ifdef YSYX_LSU_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_n;
      op_ren    <= op_ren_n;
      op_funct3 <= op_funct3_n;
      op_off    <= op_off_n;
      out_valid <= out_valid_n;
      out_err   <= out_err_n;
      out_rdata <= out_rdata_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_wmask <= mem_wmask_n;
`ifdef YSYX_LSU_TIMEOUT_EN
      cnt       <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Self-checking bench for ysyx_24100005_lsu: directed vector table, random ops against a reference model,
// and hand-written wait/timeout/reset sequences.
module tb_ysyx_24100005_lsu;

  logic        clk, rst;
  logic        in_valid, in_ready, in_ren, in_wen;
  logic [31:0] in_addr, in_wdata;
  logic [2:0]  in_funct3;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  ysyx_24100005_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_funct3(in_funct3),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_err;
    logic        exp_req;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[16];

  // Observations from the most recent operation
  logic        obs_err, obs_req, obs_we, obs_stable, obs_busy_ok;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic [3:0]  obs_wmask;
  int          obs_lat, obs_req_cyc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model derived from the RV32 access rules
  task automatic model(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       output logic err, output logic req, output logic [31:0] rd,
                       output logic [3:0] wm, output logic [31:0] wd);
    int size;
    int off;
    bit sgn;
    bit ok;
    logic [31:0] v, m;
    size = 0; sgn = 0; ok = 0;
    off = int'(addr % 32'd4);
    if (ren && !wen) begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; ok = 1; end
        3'd1: begin size = 2; sgn = 1; ok = 1; end
        3'd2: begin size = 4; ok = 1; end
        3'd4: begin size = 1; ok = 1; end
        3'd5: begin size = 2; ok = 1; end
        default: ok = 0;
      endcase
    end else if (wen && !ren) begin
      case (f3)
        3'd0: begin size = 1; ok = 1; end
        3'd1: begin size = 2; ok = 1; end
        3'd2: begin size = 4; ok = 1; end
        default: ok = 0;
      endcase
    end
    if (ok && (off % size) != 0) ok = 0;
    err = (ren || wen) && !ok;
    req = ok;
    rd = 32'd0; wm = 4'd0; wd = 32'd0;
    if (ok && ren) begin
      m = (size == 1) ? 32'h0000_00FF : (size == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      v = (rdata >> (8 * off)) & m;
      if (sgn && size < 4 && v[8*size-1]) v = v | ~m;
      rd = v;
    end
    if (ok && wen) begin
      wm = 4'(((1 << size) - 1) << off);
      wd = wdata << (8 * off);
    end
  endtask

  // Issue one op, play the memory with ack after ack_d waits, hold out_ready low ready_d cycles
  task automatic do_op(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input int ack_d, input int ready_d);
    int waited;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_ren = ren; in_wen = wen; in_funct3 = f3; in_addr = addr; in_wdata = wdata;
    tick();
    in_valid = 1'b0;
    in_ren = 1'($urandom); in_wen = 1'($urandom); in_funct3 = 3'($urandom);
    in_addr = $urandom; in_wdata = $urandom;
    obs_req = 0; obs_stable = 1; obs_busy_ok = 1; obs_lat = 0; obs_req_cyc = 0; waited = 0;
    obs_addr = 0; obs_we = 0; obs_wdata = 0; obs_wmask = 0;
    while (!out_valid && obs_lat < 300) begin
      if (in_ready) obs_busy_ok = 0;
      if (mem_req) begin
        if (!obs_req) begin
          obs_req = 1; obs_addr = mem_addr; obs_we = mem_we; obs_wdata = mem_wdata; obs_wmask = mem_wmask;
        end else if (mem_addr !== obs_addr || mem_we !== obs_we || mem_wdata !== obs_wdata ||
                     mem_wmask !== obs_wmask) begin
          obs_stable = 0;
        end
        obs_req_cyc++;
        mem_ack = (waited == ack_d);
        mem_rdata = mem_ack ? rdata : $urandom;
        waited++;
      end else begin
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
      end
      tick();
      obs_lat++;
    end
    check("out_valid_reached", 32'(out_valid), 32'd1);
    obs_err = out_err;
    obs_rdata = out_rdata;
    for (int i = 0; i < ready_d; i++) begin
      out_ready = 1'b0;
      mem_ack = 1'($urandom);
      if (in_ready || !out_valid || mem_req || out_err !== obs_err || out_rdata !== obs_rdata)
        obs_busy_ok = 0;
      tick();
    end
    if (in_ready || mem_req || out_err !== obs_err || out_rdata !== obs_rdata) obs_busy_ok = 0;
    out_ready = 1'b1;
    mem_ack = 1'b0;
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  task automatic compare(input int id, input logic wen, input int ack_d, input logic exp_err,
                         input logic exp_req, input logic [31:0] exp_rdata,
                         input logic [3:0] exp_wmask, input logic [31:0] exp_wdata,
                         input logic [31:0] addr);
    string t;
    t = $sformatf("op%0d", id);
    check({t, "_err"}, 32'(obs_err), 32'(exp_err));
    check({t, "_rdata"}, obs_rdata, exp_rdata);
    check({t, "_req_seen"}, 32'(obs_req), 32'(exp_req));
    check({t, "_latency"}, 32'(obs_lat), exp_req ? 32'(ack_d + 2) : 32'd1);
    check({t, "_busy"}, 32'(obs_busy_ok), 32'd1);
    if (exp_req) begin
      check({t, "_addr"}, obs_addr, addr & 32'hFFFF_FFFC);
      check({t, "_we"}, 32'(obs_we), 32'(wen));
      check({t, "_wmask"}, 32'(obs_wmask), 32'(exp_wmask));
      check({t, "_req_cycles"}, 32'(obs_req_cyc), 32'(ack_d + 1));
      check({t, "_req_stable"}, 32'(obs_stable), 32'd1);
      if (wen) check({t, "_wdata"}, obs_wdata, exp_wdata);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_err"}, 32'(out_err), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_out_rdata"}, out_rdata, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_wmask"}, 32'(mem_wmask), 32'd0);
  endtask

  task automatic accept(input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    in_valid = 1'b1; in_ren = ren; in_wen = wen; in_funct3 = f3; in_addr = addr; in_wdata = wdata;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic e, q;
    logic [31:0] rd, wd, a, w, r;
    logic [3:0] wm;
    logic ren, wen;
    logic [2:0] f3;
    int n;

    vecs[0]  = '{1'b0, 1'b1, 3'd0, 32'h8000_0003, 32'h0000_00AB, 32'h0, 1'b0, 1'b1, 32'h0,         4'b1000, 32'hAB00_0000};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 32'h8000_0002, 32'h0, 32'h1280_3456, 1'b0, 1'b1, 32'hFFFF_FF80, 4'b0000, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 3'd4, 32'h8000_0002, 32'h0, 32'h1280_3456, 1'b0, 1'b1, 32'h0000_0080, 4'b0000, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 3'd1, 32'h8000_0002, 32'h0, 32'h1280_3456, 1'b0, 1'b1, 32'h0000_1280, 4'b0000, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 3'd2, 32'h8000_0002, 32'h0, 32'h1280_3456, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 3'd5, 32'h8000_0000, 32'h0, 32'h1234_F00D, 1'b0, 1'b1, 32'h0000_F00D, 4'b0000, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 3'd1, 32'h8000_0000, 32'h0, 32'h1234_F00D, 1'b0, 1'b1, 32'hFFFF_F00D, 4'b0000, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 3'd1, 32'h8000_0002, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 32'h0,         4'b1100, 32'h5678_0000};
    vecs[8]  = '{1'b1, 1'b1, 3'd2, 32'h8000_0000, 32'h1111_1111, 32'h0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 3'd2, 32'h8000_0000, 32'h1111_1111, 32'h0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 3'd3, 32'h8000_0000, 32'h0, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 3'd4, 32'h8000_0000, 32'h2222_2222, 32'h0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 3'd2, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0000, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 3'd1, 32'h8000_0001, 32'h3333_3333, 32'h0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 3'd0, 32'h8000_0001, 32'h0, 32'h1280_3456, 1'b0, 1'b1, 32'h0000_0034, 4'b0000, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 3'd0, 32'h8000_0001, 32'hFFFF_FFCD, 32'h0, 1'b0, 1'b1, 32'h0,         4'b0010, 32'hFFFF_CD00};

    rst = 1'b1; in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_addr = '0; in_wdata = '0;
    in_funct3 = '0; out_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].ren, vecs[i].wen, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, i % 3, i % 2);
      compare(i, vecs[i].wen, i % 3, vecs[i].exp_err, vecs[i].exp_req, vecs[i].exp_rdata,
              vecs[i].exp_wmask, vecs[i].exp_wdata, vecs[i].addr);
    end

    // Slow memory and stalled writeback
    do_op(1'b1, 1'b0, 3'd2, 32'h8000_0040, 32'h0, 32'hCAFE_F00D, 5, 3);
    compare(100, 1'b0, 5, 1'b0, 1'b1, 32'hCAFE_F00D, 4'b0000, 32'h0, 32'h8000_0040);

    // Randomised ops against the reference model
    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(0, 9);
      ren = (n == 0) ? 1'b1 : (n == 1) ? 1'b0 : 1'($urandom);
      wen = (n == 0) ? 1'b1 : (n == 1) ? 1'b0 : ~ren;
      f3 = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom);
      a = $urandom; w = $urandom; r = $urandom;
      model(ren, wen, f3, a, w, r, e, q, rd, wm, wd);
      do_op(ren, wen, f3, a, w, r, $urandom_range(0, 3), $urandom_range(0, 2));
      compare(200 + i, wen, obs_req_cyc - 1, e, q, rd, wm, wd, a);
    end

`ifndef YSYX_LSU_TIMEOUT_EN
    // No ack: request holds indefinitely, then reset abandons it
    accept(1'b0, 1'b1, 3'd2, 32'h8000_0020, 32'h1357_2468);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (mem_req) n++;
      tick();
    end
    check("noack_req_cycles", 32'(n), 32'd100);
    check("noack_no_valid", 32'(out_valid), 32'd0);
`else
    // No ack: request abandoned after the timeout with an error
    accept(1'b1, 1'b0, 3'd2, 32'h8000_0020, 32'h0);
    n = 0;
    while (mem_req && n < 50) begin
      n++;
      tick();
    end
    check("timeout_req_cycles", 32'(n), 32'd4);
    n = 0;
    while (!out_valid && n < 5) begin
      n++;
      tick();
    end
    check("timeout_valid", 32'(out_valid), 32'd1);
    check("timeout_err", 32'(out_err), 32'd1);
    check("timeout_rdata", out_rdata, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    accept(1'b0, 1'b1, 3'd2, 32'h8000_0020, 32'h1357_2468);
    tick();
`endif
    check("pre_reset_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_values("midreq_reset");
    #2;
    rst = 1'b0;
    tick();
    do_op(1'b0, 1'b1, 3'd2, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0);
    compare(300, 1'b1, 0, 1'b0, 1'b1, 32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h8000_0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24100005_lsu.md
Name: ysyx_24100005_lsu

Overview:
Load/store unit downstream of the execute/decode datapath in the NPC core. Accepts one memory operation per handshake: address, store data, funct3 and a read or write strobe. Drives a single-outstanding request/ack memory port, applies byte-lane masking on stores and extraction plus sign/zero extension on loads. Returns the result to writeback through a valid/ready handshake.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; fixed at 32 for RV32, lanes = DATA_W/8
TIMEOUT_CYC, 255, ack wait limit; used only with the optional feature

Ports:
clk  in  1  core clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  LSU can accept
in_ren  in  1  load
in_wen  in  1  store; in_ren and in_wen both 1 is an error
in_addr  in  ADDR_W  byte address
in_wdata  in  DATA_W  store data, right-aligned
in_funct3  in  3  RV32 load/store funct3
out_valid  out  1  result valid
out_ready  in  1  writeback can take result
out_rdata  out  DATA_W  extended load data, 0 for stores/errors
out_err  out  1  misaligned, illegal funct3, ren&wen, or timeout
mem_req  out  1  memory request
mem_we  out  1  1=write
mem_addr  out  ADDR_W  word-aligned address (in_addr & ~3)
mem_wdata  out  DATA_W  lane-shifted store data
mem_wmask  out  4  byte-lane strobe
mem_ack  in  1  request complete; mem_rdata valid same cycle
mem_rdata  in  DATA_W  full read word

Behaviour:
- Reset (async, immediate): state IDLE; in_ready, out_valid, out_err, mem_req, mem_we = 0; out_rdata, mem_addr, mem_wdata = 0; mem_wmask = 4'b0000.
- FSM states: IDLE, REQ, RESP. in_ready = (state==IDLE) & ~rst.
- IDLE: on in_valid&in_ready, latch all inputs. A legal op with ren^wen goes to REQ. An op with neither ren nor wen goes to RESP with err=0, rdata=0. An illegal op goes to RESP with err=1, rdata=0, and no memory transaction.
- Legal: loads funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Halfword needs addr[0]=0. Word needs addr[1:0]=0.
- REQ: mem_req=1; mem_addr, mem_we, mem_wdata, mem_wmask are registered and held stable until mem_ack. On mem_ack, capture the processed read word and go to RESP. mem_req drops the following cycle.
- Store mask: SB is 1<<addr[1:0]; SH is 4'b0011<<addr[1:0]; SW is 4'b1111. mem_wdata = in_wdata << (8*addr[1:0]). On loads, mem_wmask = 0.
- Load extract: byte/half selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- RESP: out_valid=1; out_rdata/out_err held stable until out_ready; then go to IDLE. in_ready is not asserted in the same cycle (no bypass).
- Latency: with ack in the first REQ cycle, out_valid rises 2 cycles after the accept edge. Error/no-op ops take 1 cycle.
- Only one operation is in flight. mem_ack outside REQ is ignored.
- rst mid-REQ drops mem_req combinationally. The pending op is discarded; the memory side must tolerate the abandoned request.

Optional Feature:
YSYX_LSU_TIMEOUT_EN:
- Defined: an 8-bit counter runs in REQ and clears on entry. When the count reaches TIMEOUT_CYC without mem_ack, the LSU drops mem_req and goes to RESP with out_err=1 and out_rdata=0.
- Undefined: no counter; REQ waits indefinitely.

Decomposition:
- Package ysyx_24100005_lsu_pkg: funct3 localparams (LB..LHU, SB..SW) and FSM state encoding.
- Sub-module ysyx_24100005_lsu_align: purely combinational. Store mask/shift and load extract/extend, driven by funct3, addr[1:0] and data.
- FSM, latches and timeout stay in the top module.

Test Plan:
- SB addr 0x8000_0003, wdata 0x0000_00AB, ack immediate -> mem_addr 0x8000_0000, wmask 4'b1000, mem_wdata 0xAB00_0000, out_valid 2 cycles after accept, err=0.
- LB/LBU addr 0x8000_0002, mem_rdata 0x1280_3456 -> LB out_rdata 0xFFFF_FF80; LBU 0x0000_0080. LH addr 0x8000_0002 -> 0x0000_1280.
- LW addr 0x8000_0002 -> mem_req never asserted, out_valid next cycle, out_err=1, out_rdata 0.
- mem_ack delayed 5 cycles, then out_ready held 0 for 3 cycles -> mem_req/addr/wmask stable through the wait; out_valid/rdata stable; in_ready=0 throughout.
- rst pulsed during REQ -> mem_req 0 in the same cycle, all outputs at reset values; a subsequent SW 0x8000_0010 of 0xDEAD_BEEF completes with wmask 4'b1111.
- With YSYX_LSU_TIMEOUT_EN and TIMEOUT_CYC=4, no ack -> mem_req drops after 4 REQ cycles, out_err=1. Without the macro, mem_req stays high for 100 cycles.
